// File: rtl/div_unit_iter.sv
// rtl/div_unit_iter.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Takes WIDTH+1 cycles per normal op; divide-by-zero and signed overflow skip the iteration.
module div_unit_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rem_op_q, rem_op_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;

  logic             is_signed;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_rem, step_quo, fin_quo, fin_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    result_d  = result_q;
    rem_op_d  = rem_op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;

    is_signed = ~funct3[0];
    // Partial remainder shifted left with the next dividend bit, minus the divisor;
    // the borrow out of bit WIDTH says whether the trial subtraction failed.
    diff      = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
    step_rem  = diff[WIDTH] ? {rem_q[WIDTH-2:0], a_q[WIDTH-1]} : diff[WIDTH-1:0];
    step_quo  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    fin_quo   = quo_neg_q ? -step_quo : step_quo;
    fin_rem   = rem_neg_q ? -step_rem : step_rem;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
          b_d       = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
          quo_d     = '0;
          rem_d     = '0;
          cnt_d     = '0;
          rem_op_d  = funct3[1];
          quo_neg_d = is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          rem_neg_d = is_signed & src_a[WIDTH-1];
          if (src_b == '0) begin
            result_d = funct3[1] ? src_a : '1;
            state_d  = S_DONE;
          end else if (is_signed && src_a == MIN_NEG && src_b == '1) begin
            result_d = funct3[1] ? '0 : MIN_NEG;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        a_d   = {a_q[WIDTH-2:0], 1'b0};
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          cnt_d    = '0;
          result_d = rem_op_q ? fin_rem : fin_quo;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A flush squashes whatever was in progress, including a same-cycle start.
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      rem_op_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      rem_op_q  <= rem_op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  assign stall  = (state_q == S_IDLE && start && !flush) || (state_q == S_CALC);
  assign done   = (state_q == S_DONE) && !flush;
  assign result = result_q;
endmodule

// File: tb/tb_div_unit_iter.sv
// tb/tb_div_unit_iter.sv - directed self-checking bench for div_unit_iter
module tb_div_unit_iter;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stall, done;
  logic [31:0] result;
  int checks = 0;
  int errors = 0;

  div_unit_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .src_a(src_a),
    .src_b(src_b), .flush(flush), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents an op from the current cycle (cycle 0) and holds start until done,
  // as the stalled pipeline would; returns the done cycle, the result, and
  // the number of cycles whose stall level disagreed with "high until done".
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output logic [31:0] res, output int stall_err);
    done_cyc  = -1;
    stall_err = 0;
    res       = 'x;
    start = 1'b1; funct3 = f; src_a = a; src_b = b;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (done) begin
        done_cyc = c;
        if (stall !== 1'b0) stall_err++;
        res = result;
        next_cycle();
        break;
      end
      if (stall !== 1'b1) stall_err++;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'b100; src_a = 32'd9; src_b = 32'd2;
    next_cycle();
    next_cycle();
    rst = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || stall !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: done=%b stall=%b result=%h, want 0 0 00000000", done, stall, result);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_start_ignored: done=%b result=%h, want 0 00000000", done, result);
    end
  endtask

  task automatic test_normal();
    logic [2:0]  f [4]   = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a [4]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'hFFFF_FFFF};
    logic [31:0] b [4]   = '{32'd2, 32'd2, 32'd7, 32'd16};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd15};
    int dc, se;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], dc, r, se);
      start = 1'b0;
      checks++;
      if (r !== exp[i]) begin
        errors++;
        $display("FAIL normal_result[%0d]: got %h, want %h", i, r, exp[i]);
      end
      checks++;
      if (dc !== 33 || se !== 0) begin
        errors++;
        $display("FAIL normal_timing[%0d]: done cycle %0d stall errs %0d, want 33 and 0", i, dc, se);
      end
      next_cycle();
    end
    // Result register holds after the done pulse.
    #1;
    checks++;
    if (result !== 32'd15 || done !== 1'b0) begin
      errors++;
      $display("FAIL result_hold: result=%h done=%b, want 0000000f 0", result, done);
    end
  endtask

  task automatic test_mixed_signs();
    int dc, se;
    logic [31:0] r;
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, dc, r, se);
    start = 1'b0;
    checks++;
    if (r !== 32'hFFFF_FFFD || dc !== 33) begin
      errors++;
      $display("FAIL div_7_by_m2: got %h at %0d, want fffffffd at 33", r, dc);
    end
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, dc, r, se);
    start = 1'b0;
    checks++;
    if (r !== 32'd1 || dc !== 33) begin
      errors++;
      $display("FAIL rem_7_by_m2: got %h at %0d, want 00000001 at 33", r, dc);
    end
    run_op(3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, dc, r, se);
    start = 1'b0;
    checks++;
    if (r !== 32'hFFFF_FFFF || dc !== 33) begin
      errors++;
      $display("FAIL rem_m7_by_m2: got %h at %0d, want ffffffff at 33", r, dc);
    end
  endtask

  task automatic test_special();
    logic [2:0]  f [5]   = '{3'b100, 3'b110, 3'b101, 3'b100, 3'b110};
    logic [31:0] a [5]   = '{32'd5, 32'd5, 32'd0, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b [5]   = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    int dc, se;
    logic [31:0] r;
    for (int i = 0; i < 5; i++) begin
      run_op(f[i], a[i], b[i], dc, r, se);
      start = 1'b0;
      checks++;
      if (r !== exp[i] || dc !== 1 || se !== 0) begin
        errors++;
        $display("FAIL special[%0d]: got %h at cycle %0d stall errs %0d, want %h at 1 and 0",
                 i, r, dc, se, exp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2, se1, se2;
    logic [31:0] r1, r2;
    run_op(3'b101, 32'd100, 32'd7, dc1, r1, se1);
    run_op(3'b111, 32'hFFFF_FFFF, 32'd16, dc2, r2, se2);
    start = 1'b0;
    checks++;
    if (r1 !== 32'd14 || r2 !== 32'd15) begin
      errors++;
      $display("FAIL b2b_results: got %h %h, want 0000000e 0000000f", r1, r2);
    end
    checks++;
    if (dc1 + 1 + dc2 !== 67 || se1 !== 0 || se2 !== 0) begin
      errors++;
      $display("FAIL b2b_timing: second done at %0d stall errs %0d/%0d, want 67 and 0",
               dc1 + 1 + dc2, se1, se2);
    end
    next_cycle();
  endtask

  task automatic test_flush();
    int dc, se, seen;
    logic [31:0] r;
    run_op(3'b101, 32'd100, 32'd7, dc, r, se);
    start = 1'b0;
    next_cycle();
    seen = 0;
    start = 1'b1; funct3 = 3'b100; src_a = 32'd100; src_b = 32'd3;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (done) seen++;
      next_cycle();
    end
    flush = 1'b1;
    #1;
    if (done) seen++;
    next_cycle();
    flush = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (seen !== 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_done: done pulses %0d, want 0", seen);
    end
    checks++;
    if (stall !== 1'b0 || result !== 32'd14) begin
      errors++;
      $display("FAIL flush_state: stall=%b result=%h, want 0 0000000e", stall, result);
    end
    run_op(3'b101, 32'd9, 32'd3, dc, r, se);
    start = 1'b0;
    checks++;
    if (r !== 32'd3 || dc + 11 !== 44) begin
      errors++;
      $display("FAIL flush_restart: got %h at cycle %0d, want 00000003 at 44", r, dc + 11);
    end
    // flush together with start in IDLE must not accept the op.
    next_cycle();
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; src_a = 32'd8; src_b = 32'd0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_stall: stall=%b, want 0", stall);
    end
    next_cycle();
    start = 1'b0; flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (done || stall) seen++;
      next_cycle();
    end
    checks++;
    if (seen !== 0 || result !== 32'd3) begin
      errors++;
      $display("FAIL flush_start_ignored: busy cycles %0d result=%h, want 0 00000003", seen, result);
    end
  endtask

  task automatic test_mid_reset();
    int dc, se, seen;
    logic [31:0] r;
    start = 1'b1; funct3 = 3'b100; src_a = 32'd100; src_b = 32'd3;
    for (int c = 0; c < 15; c++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (result !== 32'h0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: result=%h done=%b stall=%b, want 00000000 0 0", result, done, stall);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done || stall) seen++;
      next_cycle();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: busy cycles %0d, want 0", seen);
    end
    run_op(3'b111, 32'd100, 32'd3, dc, r, se);
    start = 1'b0;
    checks++;
    if (r !== 32'd1 || dc !== 33) begin
      errors++;
      $display("FAIL mid_reset_recover: got %h at %0d, want 00000001 at 33", r, dc);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_mixed_signs();
    test_special();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
